// File: rtl/frame_bus_arbiter_if.sv
// rtl/frame_bus_arbiter_if.sv - capture, display and memory bus signals of the frame bus arbiter
interface frame_bus_arbiter_if;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_full;
    logic        wr_overflow;
    logic        rd_req;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] m_addr;
    logic        m_write;
    logic        m_read;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_waitrequest;

    // Arbiter side: owns the FIFO status, read return and bus command
    modport master (
        input  wr_data, wr_valid, rd_req, m_rdata, m_waitrequest,
        output wr_full, wr_overflow, rd_busy, rd_data, rd_valid,
        output m_addr, m_write, m_read, m_wdata
    );

    // Environment side: capture source, display sink and memory slave
    modport slave (
        output wr_data, wr_valid, rd_req, m_rdata, m_waitrequest,
        input  wr_full, wr_overflow, rd_busy, rd_data, rd_valid,
        input  m_addr, m_write, m_read, m_wdata
    );
endinterface

// File: rtl/frame_bus_arbiter.sv
// rtl/frame_bus_arbiter.sv - shares one memory bus between a capture write FIFO and display reads
module frame_bus_arbiter #(
    parameter int FRAME_WORDS = 307200,
    parameter int WFIFO_DEPTH = 8
) (
    input logic              ctrl_clk,
    input logic              reset_n,
    frame_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(WFIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C    = CW'(WFIFO_DEPTH / 2);
    localparam logic [31:0]   LAST_ADDR = 32'((FRAME_WORDS - 1) * 4);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state, state_nxt;

    logic [31:0]   mem [WFIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          full, push, pop;

    logic          pending, last_write, busy;
    logic          grant_write, grant_read, write_done, read_done;

    logic [31:0]   wr_addr, rd_addr;
    logic [31:0]   m_addr_q, m_wdata_q, rd_data_q;
    logic          m_write_q, m_read_q, rd_valid_q, overflow_q;

    // Frame addresses step by one word and wrap after the last word of the buffer
    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == LAST_ADDR) ? 32'd0 : a + 32'd4;
    endfunction

    // Fullness is taken from the registered count, so a pop in the same cycle never frees room
    assign full = (count == DEPTH_C);
    assign push = bus.wr_valid && !full;
    assign pop  = grant_write;
    assign busy = pending || (state == READ);

    assign bus.wr_full     = full;
    assign bus.wr_overflow = overflow_q;
    assign bus.rd_busy     = busy;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_write     = m_write_q;
    assign bus.m_read      = m_read_q;
    assign bus.m_wdata     = m_wdata_q;

    // State register
    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grant decision in IDLE (round-robin, write forced when FIFO is half full) and command completion
    always_comb begin
        state_nxt   = state;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        write_done  = 1'b0;
        read_done   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && pending) begin
                    if (count >= HALF_C || !last_write) grant_write = 1'b1;
                    else                                grant_read  = 1'b1;
                end else if (count != '0) begin
                    grant_write = 1'b1;
                end else if (pending) begin
                    grant_read = 1'b1;
                end
                if (grant_write)     state_nxt = WRITE;
                else if (grant_read) state_nxt = READ;
            end
            WRITE: begin
                if (!bus.m_waitrequest) begin
                    write_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            READ: begin
                if (!bus.m_waitrequest) begin
                    read_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge ctrl_clk) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    // Write FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.wr_valid && full) overflow_q <= 1'b1;
        end
    end

    // Bus command registers, address counters, read return and request bookkeeping
    always_ff @(posedge ctrl_clk) begin
        if (!reset_n) begin
            m_write_q  <= 1'b0;
            m_read_q   <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pending    <= 1'b0;
            last_write <= 1'b0;
        end else begin
            if (grant_write) begin
                m_write_q <= 1'b1;
                m_addr_q  <= wr_addr;
                m_wdata_q <= mem[rptr];
            end else if (grant_read) begin
                m_read_q <= 1'b1;
                m_addr_q <= rd_addr;
            end
            if (write_done) begin
                m_write_q  <= 1'b0;
                wr_addr    <= next_addr(wr_addr);
                last_write <= 1'b1;
            end
            if (read_done) begin
                m_read_q   <= 1'b0;
                rd_addr    <= next_addr(rd_addr);
                rd_data_q  <= bus.m_rdata;
                last_write <= 1'b0;
            end
            rd_valid_q <= read_done;
            if (read_done)                pending <= 1'b0;
            else if (bus.rd_req && !busy) pending <= 1'b1;
        end
    end
endmodule

// File: doc/frame_bus_arbiter.md
FRAME_BUS_ARBITER -- requirements
Module: frame_bus_arbiter

Interface
REQ-001 Parameter FRAME_WORDS, default 307200, words per frame buffer (640x480); address wrap point.
REQ-002 Parameter WFIFO_DEPTH, default 8, write FIFO depth in words (power of 2, >=4).
REQ-003 Clock ctrl_clk; reset reset_n, synchronous, active-low.
REQ-004 ctrl_clk  in  1  sole clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 wr_data  in  32  pixel word from capture side.
REQ-007 wr_valid  in  1  wr_data valid this cycle; no back pressure.
REQ-008 wr_full  out  1  write FIFO holds WFIFO_DEPTH words.
REQ-009 wr_overflow  out  1  sticky: a word was dropped.
REQ-010 rd_req  in  1  one-cycle request for the next display word.
REQ-011 rd_busy  out  1  read request pending or in flight.
REQ-012 rd_data  out  32  returned display word.
REQ-013 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-014 m_addr  out  32  bus byte address, multiple of 4.
REQ-015 m_write / m_read  out  1 each  bus commands, never both high.
REQ-016 m_wdata  out  32  bus write data.
REQ-017 m_rdata  in  32  bus read data, valid in the cycle m_read=1 and m_waitrequest=0.
REQ-018 m_waitrequest  in  1  bus stall; command completes in the first cycle it is low.

Function
REQ-019 Write FIFO: push when wr_valid=1 and wr_full=0; wr_valid=1 while wr_full=1 drops the word and sets wr_overflow; fullness evaluated at cycle start, so a same-cycle pop does not admit a push when full.
REQ-020 Read request: rd_req=1 while rd_busy=0 sets a pending flag; rd_req while rd_busy=1 is ignored.
REQ-021 FSM states IDLE, WRITE, READ.
REQ-022 IDLE: if FIFO non-empty and read pending, grant goes to the requester not served last (round-robin), except write wins whenever FIFO count >= WFIFO_DEPTH/2; else grant whichever is pending; else stay IDLE.
REQ-023 On entering WRITE: pop FIFO head to m_wdata, m_addr=wr_addr, m_write=1; hold all stable while m_waitrequest=1.
REQ-024 WRITE, m_waitrequest=0: complete; wr_addr += 4; m_write=0 next cycle; return to IDLE.
REQ-025 On entering READ: m_addr=rd_addr, m_read=1; hold while m_waitrequest=1.
REQ-026 READ, m_waitrequest=0: capture m_rdata into rd_data, rd_valid=1 next cycle for exactly one cycle, clear pending, rd_addr += 4, m_read=0, return to IDLE.
REQ-027 At least one IDLE cycle between consecutive bus commands; at most one outstanding command.
REQ-028 wr_addr and rd_addr wrap to 0 after address (FRAME_WORDS-1)*4; independent counters.
REQ-029 rd_busy = pending flag OR state==READ; rd_data holds last value until next capture.

Reset
REQ-030 reset_n=0 at a clock edge: state=IDLE, m_read=m_write=0, m_addr=0, m_wdata=0, wr_addr=rd_addr=0, FIFO empty, wr_full=0, wr_overflow=0, pending=0, rd_busy=0, rd_valid=0, rd_data=0.
REQ-031 Reset mid-transaction abandons the command; m_read/m_write low in the cycle after the reset edge regardless of m_waitrequest.

Verification
REQ-032 Single write: push 0xA5A5_0001, m_waitrequest=0 -> m_write for one cycle at m_addr 0x0, m_wdata 0xA5A5_0001; next write uses 0x4.
REQ-033 Stalled read: rd_req, m_waitrequest high 3 cycles -> m_read/m_addr stable 4 cycles; m_rdata=0x1234_5678 on completion -> rd_valid pulse with rd_data 0x1234_5678, rd_busy low after.
REQ-034 Contention: FIFO count 1 and read pending, last served=write -> READ granted first, then WRITE; with FIFO count 4 (depth 8) -> WRITE first.
REQ-035 Overflow: m_waitrequest held high, 10 consecutive wr_valid -> wr_full after 8 words accepted (one may be in flight), wr_overflow=1 and stays 1 until reset; FIFO order preserved on drain.
REQ-036 Wrap: FRAME_WORDS=4, 5 writes -> addresses 0x0,0x4,0x8,0xC,0x0.
REQ-037 Reset during stalled WRITE -> m_write=0 next cycle, all outputs at REQ-030 values, next write at address 0x0.
